// File: rtl/platform_motion_pkg.sv
// Shared game constants and platform state type.
// Also used by the platform display/ROM stage.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PLAT_W   = 512;
  localparam int PLAT_H   = 64;

  typedef enum logic {
    RUN,
    HIDDEN
  } plat_state_t;

endpackage

// File: rtl/platform_motion_if.sv
// Frame-control inputs and platform position outputs.
// master: frame source/consumer side; slave: platform_motion.
interface platform_motion_if;
  logic        frame_tick;
  logic        pause;
  logic [3:0]  speed;
  logic [10:0] platform_x;
  logic [9:0]  platform_y;
  logic        platform_active;
  logic        spawn_pulse;

  modport master (
    output frame_tick, pause, speed,
    input  platform_x, platform_y,
    input  platform_active, spawn_pulse
  );

  modport slave (
    input  frame_tick, pause, speed,
    output platform_x, platform_y,
    output platform_active, spawn_pulse
  );
endinterface

// File: rtl/platform_motion_lfsr10.sv
// Seeded free-running 10-bit Fibonacci LFSR, x^10+x^7+1.
// Ports: clk, reset (sync, active-high), q (state).
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= {q[8:0], q[9] ^ q[6]};
  end

endmodule

// File: rtl/platform_motion.sv
// Platform scroll/hide/respawn position generator.
// Ports: clk, reset (sync, active-high), bus (slave).
// Build option: PLATFORM_BOB_EN adds a triangle y bob.
module platform_motion
  import game_pkg::*;
#(
  parameter int         Y_MIN          = 280,
  parameter int         Y_SPAN_LOG2    = 7,
  parameter int         RESPAWN_FRAMES = 30,
  parameter logic [9:0] LFSR_SEED      = 10'h2A5
) (
  input  logic               clk,
  input  logic               reset,
  platform_motion_if.slave   bus
);

  localparam int CW = $clog2(RESPAWN_FRAMES);
  localparam logic [9:0] YMASK =
    10'((1 << Y_SPAN_LOG2) - 1);

  plat_state_t state;
  logic [CW-1:0] cnt;
  logic [10:0] x;
  logic [9:0]  base_y;
  logic        active;
  logic        spawn;
  logic [9:0]  lfsr;
  logic        tick;
  logic [10:0] spd;

  assign tick = bus.frame_tick & ~bus.pause;
  assign spd  = {7'b0, bus.speed};

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      cnt    <= '0;
      x      <= 11'(SCREEN_W);
      base_y <= 10'(Y_MIN);
      active <= 1'b1;
      spawn  <= 1'b0;
    end else begin
      spawn <= 1'b0;
      if (tick) begin
        unique case (state)
          RUN: begin
            if (x > spd) begin
              x <= x - spd;
            end else begin
              x      <= '0;
              active <= 1'b0;
              cnt    <= '0;
              state  <= HIDDEN;
            end
          end
          HIDDEN: begin
            if (cnt == CW'(RESPAWN_FRAMES - 1)) begin
              x      <= 11'(SCREEN_W);
              base_y <= 10'(Y_MIN) + (lfsr & YMASK);
              active <= 1'b1;
              spawn  <= 1'b1;
              state  <= RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef PLATFORM_BOB_EN
  logic [2:0] bob;
  logic       up;

  // Triangle 0..7..0, stepping on each RUN tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      bob <= '0;
      up  <= 1'b1;
    end else if (tick) begin
      if (state == HIDDEN) begin
        if (cnt == CW'(RESPAWN_FRAMES - 1)) begin
          bob <= '0;
          up  <= 1'b1;
        end
      end else if (up) begin
        if (bob == 3'd7) begin
          bob <= 3'd6;
          up  <= 1'b0;
        end else begin
          bob <= bob + 3'd1;
        end
      end else begin
        if (bob == 3'd0) begin
          bob <= 3'd1;
          up  <= 1'b1;
        end else begin
          bob <= bob - 3'd1;
        end
      end
    end
  end

  assign bus.platform_y = base_y + {7'b0, bob};
`else
  assign bus.platform_y = base_y;
`endif

  assign bus.platform_x      = x;
  assign bus.platform_active = active;
  assign bus.spawn_pulse     = spawn;

endmodule

// File: tb/tb_platform_motion.sv
// Self-checking bench for platform_motion.
// Vector table, hand sequences, random vs. reference model.
module tb_platform_motion;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  platform_motion_if bus ();

  platform_motion dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  int mx, mbase, mcnt, mk, mlfsr;
  bit mact, mhid, mspawn;
  bit prev_t = 0;

  function automatic int tri_off(input int k);
    int m;
    m = k % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction

  function automatic int model_y();
`ifdef PLATFORM_BOB_EN
    return mbase + tri_off(mk);
`else
    return mbase;
`endif
  endfunction

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit t,
                            input bit p, input int s);
    if (r) begin
      mx = 640; mbase = 280; mact = 1; mhid = 0;
      mcnt = 0; mspawn = 0; mlfsr = 'h2A5; mk = 0;
    end else begin
      mspawn = 0;
      if (t && !p) begin
        if (!mhid) begin
          mk++;
          if (mx > s) mx = mx - s;
          else begin
            mx = 0; mact = 0; mhid = 1; mcnt = 0;
          end
        end else if (mcnt == 29) begin
          mx = 640; mbase = 280 + (mlfsr % 128);
          mact = 1; mspawn = 1; mhid = 0; mk = 0;
        end else begin
          mcnt++;
        end
      end
      mlfsr = ((mlfsr << 1)
              | (((mlfsr >> 9) ^ (mlfsr >> 6)) & 1))
              & 'h3FF;
    end
  endtask

  // One clock: drive at negedge, model at posedge, check +1.
  task automatic cyc(input bit r, input bit t, input bit p,
                     input int s);
    @(negedge clk);
    if (t && prev_t && !r) begin
      checks++; errors++;
      $display("FAIL tick_pulse: got 2 consecutive ticks expected 1");
    end
    prev_t = t;
    reset = r;
    bus.frame_tick = t;
    bus.pause = p;
    bus.speed = 4'(s);
    @(posedge clk);
    model_step(r, t, p, s);
    #1;
    chk("x", int'(bus.platform_x), mx);
    chk("y", int'(bus.platform_y), model_y());
    chk("active", int'(bus.platform_active), int'(mact));
    chk("spawn", int'(bus.spawn_pulse), int'(mspawn));
  endtask

  task automatic tick(input int s);
    cyc(0, 1, 0, s);
    cyc(0, 0, 0, s);
  endtask

  task automatic ptick(input int s);
    cyc(0, 1, 1, s);
    cyc(0, 0, 1, s);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    int spd;
    int n;
    int ex;
    int ea;
  } vec_t;

  vec_t tbl[8];
  int   y_exp;
  int   spawns;

  initial begin
    bus.frame_tick = 0;
    bus.pause = 0;
    bus.speed = 0;

    tbl[0] = '{4,  10, 600, 1};
    tbl[1] = '{15,  3, 595, 1};
    tbl[2] = '{0,   5, 640, 1};
    tbl[3] = '{7,  91,   3, 1};
    tbl[4] = '{7,  92,   0, 0};
    tbl[5] = '{10, 63,  10, 1};
    tbl[6] = '{10, 64,   0, 0};
    tbl[7] = '{1, 640,   0, 0};

    // reset state and 1-cycle latency
    do_reset();
    chk("rst_x", int'(bus.platform_x), 640);
    chk("rst_y", int'(bus.platform_y), 280);
    chk("rst_active", int'(bus.platform_active), 1);
    chk("rst_spawn", int'(bus.spawn_pulse), 0);
    cyc(0, 1, 0, 4);
    chk("lat_x", int'(bus.platform_x), 636);
    cyc(0, 0, 0, 4);
    for (int i = 1; i < 10; i++) tick(4);
    chk("s4_x10", int'(bus.platform_x), 600);

    // vector table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < tbl[v].n; i++) tick(tbl[v].spd);
      chk($sformatf("tbl%0d_x", v),
          int'(bus.platform_x), tbl[v].ex);
      chk($sformatf("tbl%0d_act", v),
          int'(bus.platform_active), tbl[v].ea);
    end

    // exit from x=6, hidden pause, respawn
    do_reset();
    for (int i = 0; i < 42; i++) tick(15);
    chk("pre_x", int'(bus.platform_x), 10);
    tick(4);
    chk("x6", int'(bus.platform_x), 6);
    tick(4);
    chk("x2", int'(bus.platform_x), 2);
    tick(4);
    chk("exit_x", int'(bus.platform_x), 0);
    chk("exit_act", int'(bus.platform_active), 0);
    for (int i = 0; i < 10; i++) tick(4);
    for (int i = 0; i < 5; i++) ptick(4);
    chk("hpause_act", int'(bus.platform_active), 0);
    chk("hpause_x", int'(bus.platform_x), 0);
    for (int i = 0; i < 19; i++) tick(4);
    chk("t29_act", int'(bus.platform_active), 0);
    y_exp = 280 + (mlfsr % 128);
    cyc(0, 1, 0, 4);
    chk("resp_act", int'(bus.platform_active), 1);
    chk("resp_x", int'(bus.platform_x), 640);
    chk("resp_y", int'(bus.platform_y), y_exp);
    chk("resp_y_rng",
        int'(bus.platform_y >= 280 && bus.platform_y <= 407), 1);
    chk("resp_spawn", int'(bus.spawn_pulse), 1);
    cyc(0, 0, 0, 4);
    chk("spawn_1cyc", int'(bus.spawn_pulse), 0);

    // pause in RUN, then resume
    for (int i = 0; i < 5; i++) ptick(4);
    chk("rpause_x", int'(bus.platform_x), 640);
    chk("rpause_y", int'(bus.platform_y), y_exp);
    tick(4);
    chk("resume_x", int'(bus.platform_x), 636);

    // speed 0 for 100 ticks
    spawns = 0;
    for (int i = 0; i < 100; i++) begin
      tick(0);
      if (bus.spawn_pulse) spawns++;
    end
    chk("s0_x", int'(bus.platform_x), 636);
    chk("s0_act", int'(bus.platform_active), 1);
    chk("s0_spawn", spawns, 0);

    // reset coincident with tick while hidden
    do_reset();
    for (int i = 0; i < 64; i++) tick(10);
    chk("h_act", int'(bus.platform_active), 0);
    for (int i = 0; i < 3; i++) tick(10);
    cyc(1, 1, 0, 10);
    chk("rtk_x", int'(bus.platform_x), 640);
    chk("rtk_act", int'(bus.platform_active), 1);
    chk("rtk_y", int'(bus.platform_y), 280);
    cyc(0, 0, 0, 10);

`ifdef PLATFORM_BOB_EN
    // bob triangle from reset
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      chk($sformatf("bob%0d", i),
          int'(bus.platform_y) - 280, tri_off(i));
    end
`endif

    // randomized vs model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit r, t, p;
      int s;
      r = ($urandom_range(0, 599) == 0);
      t = !prev_t && ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0) ? 15
          : int'($urandom_range(0, 15));
      cyc(r, t, p, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/platform_motion.md
Name: platform_motion

Overview:
- Upstream stage of the platform sprite renderer: produces the platform's top-left position (platform_x, platform_y) and a visibility flag, all consumed by the platform display/ROM stage.
- Scrolls the platform leftward by a programmable speed once per video frame.
- Hides the platform for a fixed number of frames once it leaves the screen.
- Respawns the platform at the right edge at a pseudo-random height.

Parameters:
- SCREEN_W, 640, visible width in pixels; respawn x coordinate.
- Y_MIN, 280, lowest respawn platform_y value (top edge).
- Y_SPAN_LOG2, 7, respawn y = Y_MIN + lfsr[Y_SPAN_LOG2-1:0]; range Y_MIN..Y_MIN+127.
- RESPAWN_FRAMES, 30, number of frame ticks the platform stays hidden before respawn.
- LFSR_SEED, 10'h2A5, nonzero reset seed of the y-selection LFSR.

Ports:
- clk  input  1  system/pixel clock.
- reset  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per frame, asserted during vblank.
- pause  input  1  when 1, frame_tick is ignored and all state holds.
- speed  input  4  pixels moved per frame, 0..15.
- platform_x  output  11  platform left-edge x.
- platform_y  output  10  platform top-edge y.
- platform_active  output  1  1 = platform is drawn; the display path gates rgb with this.
- spawn_pulse  output  1  one-cycle pulse when a new platform appears (score/difficulty hook).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); all registers load on the clk edge where reset=1.
- Reset values:
  - platform_x = SCREEN_W.
  - platform_y = Y_MIN.
  - platform_active = 1.
  - spawn_pulse = 0.
  - state = RUN.
  - respawn counter = 0.
  - lfsr = LFSR_SEED.
- LFSR:
  - 10-bit Fibonacci LFSR, taps x^10+x^7+1.
  - Advances every clk cycle not in reset, independent of pause.
  - Never reaches zero.
- Update timing: all updates occur only on a cycle where frame_tick=1 and pause=0. Outputs change on the following clk edge (1-cycle latency) and are stable for the rest of the frame.
- State RUN:
  - If platform_x > speed: platform_x <= platform_x - speed.
  - Else: platform_x <= 0, platform_active <= 0, counter <= 0, go to HIDDEN.
  - speed=0: platform_x holds; the platform never exits.
  - speed is sampled on the tick cycle only.
- State HIDDEN:
  - Each valid tick, counter increments.
  - On the tick where counter == RESPAWN_FRAMES-1, all of the following happen on that same edge:
    - platform_x <= SCREEN_W.
    - platform_y <= Y_MIN + lfsr[Y_SPAN_LOG2-1:0] (zero-extended).
    - platform_active <= 1.
    - spawn_pulse <= 1 for exactly one cycle.
    - go to RUN.
- Arithmetic: platform_x compare and subtract are 11-bit unsigned with speed zero-extended. No wrap below 0 is permitted.
- pause asserted mid-HIDDEN: the counter freezes and resumes on unpause.
- reset mid-operation overrides everything, including a coincident frame_tick.
- frame_tick held high for multiple cycles: each high cycle counts as a tick. The source guarantees single-cycle pulses, and the bench checks compliance.

Optional Feature:
- Macro: PLATFORM_BOB_EN.
- Defined:
  - Adds a vertical oscillation in RUN: a 3-bit bob offset is added to the base y.
  - The offset ramps 0..7..0 as a triangle wave, one step per valid tick.
  - platform_y = base_y + offset.
  - The offset resets to 0 on respawn and on reset.
- Undefined: platform_y is constant between respawns, and no bob logic is synthesised.

Decomposition:
- Shared package (game_pkg) holds:
  - SCREEN_W / SCREEN_H constants.
  - PLAT_W = 512 and PLAT_H = 64, shared with the display/ROM stage.
  - The state enum {RUN, HIDDEN}.
- One sub-module: lfsr10 (seeded, free-running 10-bit LFSR, output q). It is reused by future obstacle spawners.

Test Plan:
- Reset, then speed=4, 10 ticks:
  - Before any tick: platform_x=640, platform_y=280, active=1.
  - After 10 ticks: platform_x=600.
  - Each update lands exactly 1 cycle after its tick.
- Exit condition:
  - Preload platform_x=6 via ticks at speed=4 and send a tick: the first tick gives x=2; the next gives x=0, active=0, state HIDDEN.
  - Also check the exact-equality case x == speed, which must also exit.
- Respawn after exit:
  - After 29 ticks, active remains 0.
  - On the 30th tick: active=1, x=640, y in 280..407 matching the reference-model LFSR value, spawn_pulse high exactly one cycle.
- pause=1 for 5 frame ticks in RUN and in HIDDEN: x, y and counter unchanged. Resume continues from the frozen values.
- speed=0 for 100 ticks: x constant, no exit, no spawn_pulse.
- Reset asserted on the same cycle as frame_tick during HIDDEN: next cycle shows reset values (x=640, active=1). With PLATFORM_BOB_EN, the bob offset sequence reads 0,1,…,7,6,…,0.
